// File: rtl/display_pkg.sv
// Shared constants and types for the display-block scanner and its key accumulator.
package display_pkg;

    localparam int unsigned NUM_BLOCKS_DEFAULT = 44;
    localparam int unsigned CHARS_PER_BLOCK    = 14;
    localparam int unsigned NAME_CHARS         = 5;

    localparam int unsigned BLOCK_W = 6;
    localparam int unsigned POS_W   = 4;
    localparam int unsigned NAME_W  = 40;
    localparam int unsigned VALUE_W = 32;
    localparam int unsigned KEY_W   = 5;
    localparam int unsigned CHAR_W  = 8;

    localparam logic [KEY_W-1:0] KEY_BS    = 5'd16;
    localparam logic [KEY_W-1:0] KEY_ENTER = 5'd17;
    localparam logic [KEY_W-1:0] KEY_CLR   = 5'd18;

    localparam logic [CHAR_W-1:0] COLON = 8'h3A;
    localparam logic [CHAR_W-1:0] SPACE = 8'h20;

    typedef enum logic [2:0] {
        GAP,
        REQ,
        WAIT,
        EMIT,
        NEXT
    } scan_state_t;

    // One block's captured response, held while its characters are emitted.
    typedef struct packed {
        logic [NAME_W-1:0]  name;
        logic [VALUE_W-1:0] value;
    } block_t;

endpackage

// File: rtl/hex_to_ascii.sv
// Maps one hex nibble to its upper-case ASCII digit.
module hex_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii_c
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii_c = 8'h30 + 8'(nibble);
        end else begin
            ascii_c = 8'h41 + 8'(nibble - 4'd10);
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Sweeps the display blocks, serializes each valid block into a 14-char ASCII stream,
// and assembles hex keypad events into committed input values.
module display_scanner
    import display_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = NUM_BLOCKS_DEFAULT,
    parameter int unsigned FRAME_GAP  = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [5:0]  display_number,
    input  logic        display_valid,
    input  logic [39:0] display_name,
    input  logic [31:0] display_value,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic [5:0]  char_block,
    output logic [3:0]  char_pos,
    output logic        frame_done,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic [31:0] edit_value,
    output logic        input_valid,
    output logic [31:0] input_value
);

    localparam int unsigned GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [POS_W-1:0]   LAST_POS   = POS_W'(CHARS_PER_BLOCK - 1);
    localparam logic [POS_W-1:0]   COLON_POS  = POS_W'(NAME_CHARS);
    localparam logic [BLOCK_W-1:0] LAST_BLOCK = BLOCK_W'(NUM_BLOCKS);
    localparam logic [GAP_W-1:0]   GAP_RELOAD = GAP_W'(FRAME_GAP - 1);

    scan_state_t        state, state_d;
    logic [BLOCK_W-1:0] blk, blk_d;
    logic [GAP_W-1:0]   gap_cnt, gap_d;
    block_t             buf_q, buf_d;

    logic [BLOCK_W-1:0] number_d;
    logic               valid_d;
    logic [CHAR_W-1:0]  data_d;
    logic [BLOCK_W-1:0] block_d;
    logic [POS_W-1:0]   pos_d;
    logic               done_d;

    logic [POS_W-1:0]   fetch_pos;
    block_t             src;
    logic [CHAR_W-1:0]  name_byte;
    logic [3:0]         nibble;
    logic [CHAR_W-1:0]  hex_char;
    logic [CHAR_W-1:0]  char_next;

    // Next character to present: pos 0 straight from the responder at the end of WAIT,
    // later positions from the captured block buffer.
    always_comb begin
        fetch_pos = (state == WAIT) ? '0 : char_pos + 4'd1;
        src       = (state == WAIT) ? block_t'({display_name, display_value}) : buf_q;
        name_byte = 8'h00;
        nibble    = 4'h0;
        case (fetch_pos)
            4'd0:    name_byte = src.name[39:32];
            4'd1:    name_byte = src.name[31:24];
            4'd2:    name_byte = src.name[23:16];
            4'd3:    name_byte = src.name[15:8];
            4'd4:    name_byte = src.name[7:0];
            4'd6:    nibble    = src.value[31:28];
            4'd7:    nibble    = src.value[27:24];
            4'd8:    nibble    = src.value[23:20];
            4'd9:    nibble    = src.value[19:16];
            4'd10:   nibble    = src.value[15:12];
            4'd11:   nibble    = src.value[11:8];
            4'd12:   nibble    = src.value[7:4];
            4'd13:   nibble    = src.value[3:0];
            default: ;
        endcase
    end

    hex_to_ascii u_hex_to_ascii (
        .nibble  (nibble),
        .ascii_c (hex_char)
    );

    always_comb begin
        if (fetch_pos < COLON_POS) begin
            char_next = (name_byte == 8'h00) ? SPACE : name_byte;
        end else if (fetch_pos == COLON_POS) begin
            char_next = COLON;
        end else begin
            char_next = hex_char;
        end
    end

    // Scanner state and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= GAP;
            blk            <= '0;
            gap_cnt        <= '0;
            buf_q          <= '0;
            display_number <= '0;
            char_valid     <= 1'b0;
            char_data      <= '0;
            char_block     <= '0;
            char_pos       <= '0;
            frame_done     <= 1'b0;
        end else begin
            state          <= state_d;
            blk            <= blk_d;
            gap_cnt        <= gap_d;
            buf_q          <= buf_d;
            display_number <= number_d;
            char_valid     <= valid_d;
            char_data      <= data_d;
            char_block     <= block_d;
            char_pos       <= pos_d;
            frame_done     <= done_d;
        end
    end

    // Reset leaves the FSM in GAP with an expired counter, so scanning starts at block 1
    // on the first cycle out of reset.
    always_comb begin
        state_d  = state;
        blk_d    = blk;
        gap_d    = gap_cnt;
        buf_d    = buf_q;
        number_d = display_number;
        valid_d  = char_valid;
        data_d   = char_data;
        block_d  = char_block;
        pos_d    = char_pos;
        done_d   = 1'b0;

        case (state)
            GAP: begin
                if (gap_cnt == '0) begin
                    state_d  = REQ;
                    blk_d    = 6'd1;
                    number_d = 6'd1;
                end else begin
                    gap_d = gap_cnt - GAP_W'(1);
                end
            end

            REQ: begin
                state_d = WAIT;
            end

            WAIT: begin
                buf_d = src;
                if (display_valid) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                    data_d  = char_next;
                    block_d = blk;
                    pos_d   = '0;
                end else begin
                    state_d = NEXT;
                end
            end

            EMIT: begin
                if (char_valid && char_ready) begin
                    if (char_pos == LAST_POS) begin
                        valid_d = 1'b0;
                        state_d = NEXT;
                    end else begin
                        pos_d  = fetch_pos;
                        data_d = char_next;
                    end
                end
            end

            NEXT: begin
                if (blk == LAST_BLOCK) begin
                    state_d  = GAP;
                    gap_d    = GAP_RELOAD;
                    number_d = '0;
                    done_d   = 1'b1;
                end else begin
                    state_d  = REQ;
                    blk_d    = blk + 6'd1;
                    number_d = blk + 6'd1;
                end
            end

            default: begin
                state_d = GAP;
                gap_d   = '0;
            end
        endcase
    end

    // Keypad accumulator, independent of the scanner.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            edit_value  <= '0;
            input_value <= '0;
            input_valid <= 1'b0;
        end else begin
            input_valid <= 1'b0;
            if (key_valid) begin
                if (key_code < KEY_BS) begin
                    edit_value <= {edit_value[27:0], key_code[3:0]};
                end else begin
                    case (key_code)
                        KEY_BS:    edit_value <= edit_value >> 4;
                        KEY_CLR:   edit_value <= '0;
                        KEY_ENTER: begin
                            input_value <= edit_value;
                            input_valid <= 1'b1;
                            edit_value  <= '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: block serialization, stall, invalid block,
// frame gap, keypad accumulator and mid-block reset.
module tb_display_scanner;

    localparam int unsigned NB = 4;
    localparam int unsigned FG = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  display_number;
    logic        display_valid = 1'b0;
    logic [39:0] display_name  = '0;
    logic [31:0] display_value = '0;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_data;
    logic [5:0]  char_block;
    logic [3:0]  char_pos;
    logic        frame_done;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [31:0] edit_value;
    logic        input_valid;
    logic [31:0] input_value;

    logic        blk3_valid;
    logic        found;
    logic [17:0] ent;
    logic [5:0]  exp_blk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        kv;
        logic [4:0]  code;
        logic [31:0] edit;
        logic        iv;
        logic [31:0] ival;
    } key_vec_t;

    key_vec_t    kvec [23];
    logic [7:0]  exp_stream [42];
    logic [17:0] xfers [$];

    always #5 clk = ~clk;

    display_scanner #(.NUM_BLOCKS(NB), .FRAME_GAP(FG)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .display_number (display_number),
        .display_valid  (display_valid),
        .display_name   (display_name),
        .display_value  (display_value),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .char_data      (char_data),
        .char_block     (char_block),
        .char_pos       (char_pos),
        .frame_done     (frame_done),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .edit_value     (edit_value),
        .input_valid    (input_valid),
        .input_value    (input_value)
    );

    // Registered responder: answers the block number seen on the previous cycle.
    always @(posedge clk) begin
        case (display_number)
            6'd1: begin
                display_valid <= 1'b1;
                display_name  <= "RADD1";
                display_value <= 32'h0000_001F;
            end
            6'd2: begin
                display_valid <= 1'b1;
                display_name  <= {8'h41, 8'h42, 8'h00, 8'h00, 8'h5A};
                display_value <= 32'hDEAD_BEEF;
            end
            6'd3: begin
                display_valid <= blk3_valid;
                display_name  <= "ZZZZZ";
                display_value <= 32'hFFFF_FFFF;
            end
            6'd4: begin
                display_valid <= 1'b1;
                display_name  <= "XY123";
                display_value <= 32'h0123_4567;
            end
            default: begin
                display_valid <= 1'b0;
                display_name  <= '0;
                display_value <= '0;
            end
        endcase
    end

    // Record every accepted character.
    always @(negedge clk) begin
        if (resetn && char_valid && char_ready)
            xfers.push_back({char_block, char_pos, char_data});
    end

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        kvec[0]  = '{1'b1, 5'd1,  32'h1,        1'b0, 32'h0};
        kvec[1]  = '{1'b1, 5'd2,  32'h12,       1'b0, 32'h0};
        kvec[2]  = '{1'b1, 5'd10, 32'h12A,      1'b0, 32'h0};
        kvec[3]  = '{1'b1, 5'd16, 32'h12,       1'b0, 32'h0};
        kvec[4]  = '{1'b1, 5'd15, 32'h12F,      1'b0, 32'h0};
        kvec[5]  = '{1'b1, 5'd17, 32'h0,        1'b1, 32'h12F};
        kvec[6]  = '{1'b1, 5'd17, 32'h0,        1'b1, 32'h0};
        kvec[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        kvec[8]  = '{1'b1, 5'd1,  32'h1,        1'b0, 32'h0};
        kvec[9]  = '{1'b1, 5'd2,  32'h12,       1'b0, 32'h0};
        kvec[10] = '{1'b1, 5'd3,  32'h123,      1'b0, 32'h0};
        kvec[11] = '{1'b1, 5'd4,  32'h1234,     1'b0, 32'h0};
        kvec[12] = '{1'b1, 5'd5,  32'h12345,    1'b0, 32'h0};
        kvec[13] = '{1'b1, 5'd6,  32'h123456,   1'b0, 32'h0};
        kvec[14] = '{1'b1, 5'd7,  32'h1234567,  1'b0, 32'h0};
        kvec[15] = '{1'b1, 5'd8,  32'h12345678, 1'b0, 32'h0};
        kvec[16] = '{1'b1, 5'd9,  32'h23456789, 1'b0, 32'h0};
        kvec[17] = '{1'b1, 5'd25, 32'h23456789, 1'b0, 32'h0};
        kvec[18] = '{1'b0, 5'd17, 32'h23456789, 1'b0, 32'h0};
        kvec[19] = '{1'b1, 5'd17, 32'h0,        1'b1, 32'h23456789};
        kvec[20] = '{1'b1, 5'd7,  32'h7,        1'b0, 32'h23456789};
        kvec[21] = '{1'b1, 5'd18, 32'h0,        1'b0, 32'h23456789};
        kvec[22] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h23456789};

        // Frame 1 stream: block 1 "RADD1:0000001F", block 2 "AB  Z:DEADBEEF", block 4 "XY123:01234567".
        exp_stream = '{8'h52, 8'h41, 8'h44, 8'h44, 8'h31, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h46,
                       8'h41, 8'h42, 8'h20, 8'h20, 8'h5A, 8'h3A, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46,
                       8'h58, 8'h59, 8'h31, 8'h32, 8'h33, 8'h3A, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};

        resetn     = 1'b0;
        char_ready = 1'b1;
        key_valid  = 1'b0;
        key_code   = '0;
        blk3_valid = 1'b0;
        repeat (3) next_cycle();

        check("rst display_number", 32'(display_number), 32'd0);
        check("rst char_valid", 32'(char_valid), 32'd0);
        check("rst char_data", 32'(char_data), 32'd0);
        check("rst char_block", 32'(char_block), 32'd0);
        check("rst char_pos", 32'(char_pos), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst edit_value", edit_value, 32'd0);
        check("rst input_value", input_value, 32'd0);
        check("rst input_valid", 32'(input_valid), 32'd0);

        resetn = 1'b1;
        next_cycle();                                   // cycle 0: REQ block 1
        check("b1 req number", 32'(display_number), 32'd1);
        check("b1 req char_valid", 32'(char_valid), 32'd0);
        next_cycle();                                   // cycle 1: WAIT
        check("b1 wait char_valid", 32'(char_valid), 32'd0);
        for (int p = 0; p < 14; p++) begin             // cycles 2..15
            next_cycle();
            check("b1 char_valid", 32'(char_valid), 32'd1);
            check("b1 char_pos", 32'(char_pos), 32'(p));
            check("b1 char_block", 32'(char_block), 32'd1);
            check("b1 char_data", 32'(char_data), 32'(exp_stream[p]));
        end
        next_cycle();                                   // cycle 16: NEXT
        check("b1 next char_valid", 32'(char_valid), 32'd0);
        next_cycle();                                   // cycle 17: REQ block 2
        check("b2 req number", 32'(display_number), 32'd2);

        repeat (9) next_cycle();                        // cycle 26: block 2 pos 7
        check("stall start pos", 32'(char_pos), 32'd7);
        check("stall start data", 32'(char_data), 32'(exp_stream[21]));
        char_ready = 1'b0;
        for (int s = 1; s <= 5; s++) begin             // cycles 27..31
            next_cycle();
            check("stall char_valid", 32'(char_valid), 32'd1);
            check("stall char_pos", 32'(char_pos), 32'd7);
            check("stall char_block", 32'(char_block), 32'd2);
            check("stall char_data", 32'(char_data), 32'(exp_stream[21]));
        end
        char_ready = 1'b1;
        repeat (7) next_cycle();                        // cycle 38: NEXT
        check("b2 next char_valid", 32'(char_valid), 32'd0);
        next_cycle();                                   // cycle 39: REQ block 3
        check("b3 req number", 32'(display_number), 32'd3);
        next_cycle();                                   // cycle 40: WAIT
        check("b3 wait char_valid", 32'(char_valid), 32'd0);
        next_cycle();                                   // cycle 41: NEXT
        check("b3 next char_valid", 32'(char_valid), 32'd0);
        next_cycle();                                   // cycle 42: REQ block 4
        check("b4 req number", 32'(display_number), 32'd4);

        repeat (16) next_cycle();                       // cycle 58: NEXT (last block)
        check("b4 next frame_done", 32'(frame_done), 32'd0);
        check("b4 next char_valid", 32'(char_valid), 32'd0);
        next_cycle();                                   // cycle 59: first GAP cycle
        check("gap frame_done pulse", 32'(frame_done), 32'd1);
        check("gap number", 32'(display_number), 32'd0);
        blk3_valid = 1'b1;
        for (int g = 0; g < 3; g++) begin              // cycles 60..62
            next_cycle();
            check("gap frame_done low", 32'(frame_done), 32'd0);
            check("gap number", 32'(display_number), 32'd0);
        end
        next_cycle();                                   // cycle 63: REQ block 1 again
        check("frame2 req number", 32'(display_number), 32'd1);
        check("frame2 frame_done", 32'(frame_done), 32'd0);

        check("frame1 xfer count", 32'(xfers.size()), 32'd42);
        for (int i = 0; i < 42 && i < xfers.size(); i++) begin
            ent     = xfers[i];
            exp_blk = (i < 14) ? 6'd1 : ((i < 28) ? 6'd2 : 6'd4);
            check("stream data", 32'(ent[7:0]), 32'(exp_stream[i]));
            check("stream pos", 32'(ent[11:8]), 32'(i % 14));
            check("stream block", 32'(ent[17:12]), 32'(exp_blk));
        end

        for (int i = 0; i < 23; i++) begin
            key_valid = kvec[i].kv;
            key_code  = kvec[i].code;
            next_cycle();
            check("key edit_value", edit_value, kvec[i].edit);
            check("key input_valid", 32'(input_valid), 32'(kvec[i].iv));
            check("key input_value", input_value, kvec[i].ival);
        end
        key_valid = 1'b0;

        key_valid = 1'b1;
        key_code  = 5'd5;
        next_cycle();
        key_valid = 1'b0;
        check("pre-reset edit_value", edit_value, 32'h5);

        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            if (char_valid && char_pos == 4'd4) found = 1'b1;
            else next_cycle();
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL reset-wait: got no pos 4 character, expected one within 200 cycles");
        end

        resetn = 1'b0;
        next_cycle();
        check("midrst char_valid", 32'(char_valid), 32'd0);
        check("midrst char_pos", 32'(char_pos), 32'd0);
        check("midrst char_block", 32'(char_block), 32'd0);
        check("midrst char_data", 32'(char_data), 32'd0);
        check("midrst number", 32'(display_number), 32'd0);
        check("midrst edit_value", edit_value, 32'd0);
        check("midrst input_value", input_value, 32'd0);
        resetn = 1'b1;
        next_cycle();
        check("restart number", 32'(display_number), 32'd1);
        check("restart char_valid", 32'(char_valid), 32'd0);
        next_cycle();
        next_cycle();
        check("restart char_valid", 32'(char_valid), 32'd1);
        check("restart char_pos", 32'(char_pos), 32'd0);
        check("restart char_block", 32'(char_block), 32'd1);
        check("restart char_data", 32'(char_data), 32'h52);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
